// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode and control-field encodings for the CPU decoders
package ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ      = 4'd8,
        S_BNE      = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_JAL      = 4'd12
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/retire_counter.sv
// retire_counter: wrapping count of retired instructions
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    // count up once per retire, wrapping naturally
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (inc) count <= count + CNT_W'(1);
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle datapath sequencer with memory-ready wait states
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W      = 6,
    parameter int CNT_W         = 32,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_write,
    output logic                iord,
    output logic                mem_to_reg,
    output logic                reg_dest,
    output logic                alu_src_a,
    output logic                jal,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_op,
    output logic                branch_eq,
    output logic                branch_ne,
    output logic                illegal,
    output logic                retire,
    output logic [CNT_W-1:0]    retired_cnt,
    output logic [3:0]          state
);
    state_t cur, nxt, dec_nxt;
    logic rdy;
    assign rdy = mem_ready | ~USE_MEM_READY;
    assign state = cur;
    // opcode dispatch out of DECODE; unknown opcodes fall back to FETCH
    always_comb begin
        dec_nxt = (opcode == OPCODE_W'(OP_RTYPE)) ? S_RTYPE_EX :
                  (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) ? S_MEMADR :
                  (opcode == OPCODE_W'(OP_BEQ)) ? S_BEQ :
                  (opcode == OPCODE_W'(OP_BNE)) ? S_BNE :
                  (opcode == OPCODE_W'(OP_ADDI)) ? S_ADDI_EX :
                  (opcode == OPCODE_W'(OP_JAL)) ? S_JAL : S_FETCH;
    end
    // next-state sequencing; memory states stall until ready
    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:    nxt = rdy ? S_DECODE : S_FETCH;
            S_DECODE:   nxt = dec_nxt;
            S_MEMADR:   nxt = (opcode == OPCODE_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    nxt = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:    nxt = rdy ? S_FETCH : S_MEMWR;
            S_RTYPE_EX: nxt = S_RTYPE_WB;
            S_ADDI_EX:  nxt = S_ADDI_WB;
            default:    nxt = S_FETCH;
        endcase
    end
    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) cur <= S_FETCH;
        else cur <= nxt;
    // per-state output decode; write enables and pulses are masked during reset
    always_comb begin
        pc_write = 1'b0; ir_write = 1'b0; reg_write = 1'b0; mem_write = 1'b0;
        iord = 1'b0; mem_to_reg = 1'b0; reg_dest = 1'b0; alu_src_a = 1'b0; jal = 1'b0;
        alu_src_b = SRCB_REGB; pc_src = PC_ALU; alu_op = ALU_ADD;
        branch_eq = 1'b0; branch_ne = 1'b0; illegal = 1'b0; retire = 1'b0;
        case (cur)
            S_FETCH:    begin alu_src_b = SRCB_FOUR; ir_write = rdy; pc_write = rdy; end
            S_DECODE:   begin alu_src_b = SRCB_IMM_SH2; illegal = (dec_nxt == S_FETCH); end
            S_MEMADR:   begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
            S_MEMRD:    iord = 1'b1;
            S_MEMWB:    begin reg_write = 1'b1; mem_to_reg = 1'b1; retire = 1'b1; end
            S_MEMWR:    begin iord = 1'b1; mem_write = 1'b1; retire = rdy; end
            S_RTYPE_EX: begin alu_src_a = 1'b1; alu_op = ALU_FUNCT; end
            S_RTYPE_WB: begin reg_write = 1'b1; reg_dest = 1'b1; retire = 1'b1; end
            S_BEQ:      begin alu_src_a = 1'b1; alu_op = ALU_SUB; pc_src = PC_ALUOUT; branch_eq = 1'b1; retire = 1'b1; end
            S_BNE:      begin alu_src_a = 1'b1; alu_op = ALU_SUB; pc_src = PC_ALUOUT; branch_ne = 1'b1; retire = 1'b1; end
            S_ADDI_EX:  begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
            S_ADDI_WB:  begin reg_write = 1'b1; retire = 1'b1; end
            S_JAL:      begin pc_write = 1'b1; pc_src = PC_JUMP; jal = 1'b1; reg_write = 1'b1; retire = 1'b1; end
            default:    ;
        endcase
        if (reset) begin
            pc_write = 1'b0; ir_write = 1'b0; reg_write = 1'b0; mem_write = 1'b0;
            illegal = 1'b0; retire = 1'b0;
        end
    end
    retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (retire),
        .count (retired_cnt)
    );
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised control FSM for the multi-cycle datapath, the successor to the single-cycle opcode decoder. It sequences each instruction over several cycles, drives all datapath enables and mux selects as Moore outputs, and waits on a memory-ready handshake. It also flags illegal opcodes and counts retired instructions. It sits between the instruction register and the shared ALU/memory/register-file datapath.

## Interface
- `OPCODE_W`, 6: opcode field width.
- `CNT_W`, 32: retired-instruction counter width.
- `USE_MEM_READY`, 1: 1 = honour `mem_ready`; 0 = treat `mem_ready` as constant 1.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  OPCODE_W  instruction-register opcode field; stable from DECODE onward.
- `mem_ready`  in  1  memory access completes this cycle.
- `pc_write`, `ir_write`, `reg_write`, `mem_write`  out  1  datapath write enables.
- `iord`, `mem_to_reg`, `reg_dest`, `alu_src_a`, `jal`  out  1  mux selects.
- `alu_src_b`  out  2  00 = regB, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = use funct.
- `branch_eq`, `branch_ne`  out  1  conditional PC-write qualifiers.
- `illegal`  out  1  one-cycle pulse: unknown opcode.
- `retire`  out  1  one-cycle pulse: instruction completed.
- `retired_cnt`  out  CNT_W  retired-instruction count.
- `state`  out  4  current state (debug).

## Operation
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5.
  - RTYPE_EX 6, RTYPE_WB 7, BEQ 8, BNE 9.
  - ADDI_EX 10, ADDI_WB 11, JAL 12.
  - Codes 13–15 are unreachable; if entered, go to FETCH next cycle.
- Outputs are Moore per state. Any output not listed for a state is 0. `rdy` means `mem_ready | ~USE_MEM_READY`.
  - FETCH: alu_src_b=01; `ir_write` = `pc_write` = `rdy`. Hold in FETCH until `rdy`, then go to DECODE.
  - DECODE: alu_src_b=11. Next state by opcode:
    - 000000 → RTYPE_EX
    - 100011 or 101011 → MEMADR
    - 000100 → BEQ
    - 000101 → BNE
    - 001000 → ADDI_EX
    - 000011 → JAL
    - any other opcode → FETCH with `illegal`=1.
  - MEMADR: alu_src_a=1, alu_src_b=10. Next state MEMRD for LW, MEMWR for SW.
  - MEMRD: iord=1. Hold until `rdy`, then go to MEMWB.
  - MEMWB: reg_write=1, mem_to_reg=1.
  - MEMWR: iord=1, mem_write=1, held high while waiting. Leave on `rdy`.
  - RTYPE_EX: alu_src_a=1, alu_op=10.
  - RTYPE_WB: reg_write=1, reg_dest=1.
  - BEQ / BNE: alu_src_a=1, alu_op=01, pc_src=01, plus `branch_eq` / `branch_ne` respectively.
  - ADDI_EX: alu_src_a=1, alu_src_b=10.
  - ADDI_WB: reg_write=1.
  - JAL: pc_write=1, pc_src=10, jal=1, reg_write=1.
  - After MEMWB, MEMWR, RTYPE_WB, BEQ, BNE, ADDI_WB and JAL, the next state is FETCH.
- `retire` asserts in MEMWB, RTYPE_WB, BEQ, BNE, ADDI_WB and JAL. In MEMWR it asserts only in the cycle where `rdy`=1.
- `retired_cnt` increments on the same edge as `retire`; it wraps modulo 2^CNT_W with no saturation.
- Illegal opcodes never retire.

## Timing
- Reset (asynchronous, active-high):
  - `state` = FETCH and `retired_cnt` = 0 immediately.
  - While `reset`=1, all write enables, `illegal` and `retire` are forced to 0.
  - Mux selects show FETCH values: alu_src_b=01, all others 0.
- Zero-wait-state latencies, counted from the FETCH entry cycle: R-type 4, LW 5, SW 4, BEQ/BNE 3, ADDI 4, JAL 3, illegal 2.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs hold constant during the wait, except that `ir_write`/`pc_write` track `rdy`.
- Changes on `opcode` outside DECODE/MEMADR are ignored.
- Reset asserted mid-instruction (including mid-wait) abandons the instruction with no retire.
- First FETCH is the cycle after `reset` deasserts.

## Structure
- Shared package `ctrl_pkg` holds:
  - state localparams;
  - opcode constants (RTYPE, LW, SW, BEQ, BNE, ADDI, JAL);
  - `alu_op`, `alu_src_b` and `pc_src` encodings.
  - The package is reused by the single-cycle decoder and the ALU decoder.
- One sub-module, `retire_counter` (CNT_W parameter, `clk`, `reset`, `inc`, `count`).
- The FSM next-state logic and the output decode remain in this module.

## Test plan
- Zero-wait R-type (opcode 000000), `mem_ready`=1 → states 0,1,6,7,0; `reg_write`=`reg_dest`=1 in state 7; `retired_cnt` 0 → 1.
- LW (100011) with `mem_ready` low 3 cycles in MEMRD → states 0,1,2,3,3,3,3,4; `iord`=1 throughout MEMRD; `mem_to_reg`=1 in state 4; total 8 cycles.
- SW (101011) with `mem_ready` low 2 cycles → `mem_write`=1 for 3 cycles; `retire` only on the final one; `reg_write` never 1.
- BEQ, BNE and JAL back-to-back → `branch_eq` only in state 8, `branch_ne` only in state 9, `pc_src`=10 and `jal`=1 in state 12; `retired_cnt` = 3.
- Opcode 111111 → `illegal` pulse in DECODE, return to FETCH, no retire. `USE_MEM_READY`=0 with `mem_ready` tied 0 → R-type still completes in 4 cycles.
- Reset asserted during MEMRD wait → `state`=0 and `retired_cnt`=0 asynchronously, enables 0; with CNT_W=4, 16 retires wrap the count to 0.
